fir_stream_param: RTL

- Parametrised successor to the fixed-coefficient 17-bit filter (`filter_original`): a direct-form FIR with a valid-qualified sample stream and run-time programmable coefficients.
- Output rounding and saturation are configurable.
- Sits between the sample source and the output writer in the filter datapath.
- Delay line advances only on accepted samples, so sparse or bursty input streams are supported.

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_round_sat.sv | 58 +++++
 rtl/fir_stream_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared sizing helpers for the streaming FIR: address/accumulator widths
// and the saturation bounds of a signed output word.
package fir_pkg;

    // Ceiling log2, usable in constant contexts (port and parameter widths).
    function automatic int clog2(input int unsigned n);
        int          r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Accumulator width that can hold the sum of all tap products without overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    // Largest value representable in a signed out_w-bit word.
    function automatic longint sat_max(input int out_w);
        return (longint'(1) << (out_w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed out_w-bit word.
    function automatic longint sat_min(input int out_w);
        return -(longint'(1) << (out_w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational output conditioning: optional round-half-up arithmetic
// right shift of the accumulator, then clamp to the signed output range.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 37,
    parameter int SHIFT = 0,
    parameter int OUT_W = 17
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    // One guard bit so adding the rounding bias can never wrap.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OUT_W));
    localparam logic signed [RW-1:0] MINV = RW'(sat_min(OUT_W));

    logic signed [RW-1:0] wide;
    logic signed [RW-1:0] rnd;

    // Sign-extend the accumulator into the guarded width.
    always_comb begin
        wide = RW'(acc);
    end

    generate
        if (SHIFT > 0) begin : g_round
            logic signed [RW-1:0] half;
            // Add half an LSB of the result, then floor via arithmetic shift.
            always_comb begin
                half          = '0;
                half[SHIFT-1] = 1'b1;
                rnd           = (wide + half) >>> SHIFT;
            end
        end else begin : g_pass
            // No scaling requested: pass the accumulator through.
            always_comb begin
                rnd = wide;
            end
        end
    endgenerate

    // Clamp to the output range and flag when clamping occurred.
    always_comb begin
        y   = rnd[OUT_W-1:0];
        sat = 1'b0;
        if (rnd > MAXV) begin
            y   = MAXV[OUT_W-1:0];
            sat = 1'b1;
        end else if (rnd < MINV) begin
            y   = MINV[OUT_W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/fir_stream_param.sv
// Direct-form FIR on a valid-qualified sample stream with run-time
// programmable coefficients. Three stages: delay line, registered products,
// accumulate/round/saturate. One result per accepted sample, two edges later.
module fir_stream_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int COEF_W = 17,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 17,
    parameter int SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   data_in,
    input  logic                       flush,
    input  logic                       coef_we,
    input  logic [clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       out_valid,
    output logic signed [OUT_W-1:0]    data_out,
    output logic                       sat_flag
);

    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [PW-1:0]     p [TAPS];
    logic                     v0;
    logic                     v1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  rs_y;
    logic                     rs_sat;

    // Stage 0: delay line shifts only on accepted samples; flush zeroes history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) x[k] <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= in_valid;
            if (flush) begin
                x[0] <= in_valid ? data_in : '0;
                for (int unsigned k = 1; k < TAPS; k++) x[k] <= '0;
            end else if (in_valid) begin
                x[0] <= data_in;
                for (int unsigned k = 1; k < TAPS; k++) x[k] <= x[k-1];
            end
        end
    end

    // Coefficient bank; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) c[k] <= '0;
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            c[coef_addr] <= coef_data;
        end
    end

    // Stage 1: full-width products, captured only when stage 0 took a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) p[k] <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0) begin
                for (int unsigned k = 0; k < TAPS; k++) p[k] <= PW'(x[k]) * PW'(c[k]);
            end
        end
    end

    // Stage 2 adder tree: widened sum of all products.
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < TAPS; k++) acc = acc + ACC_W'(p[k]);
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc (acc),
        .y   (rs_y),
        .sat (rs_sat)
    );

    // Stage 2 output register: result and flag update only with a valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                data_out <= rs_y;
                sat_flag <= rs_sat;
            end
        end
    end

endmodule
